led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Parametrised successor to the fixed 4-LED blinker: drives N_LED board LEDs from one sysclk with four run-time selectable patterns: off, blink, chase and breathe (PWM).
- Sits directly on the board LED pins.
- Pattern timing is derived from a millisecond tick prescaler and a programmable step period.

Parameters:
- N_LED, 4, number of LED outputs (>=2).
- CLK_HZ, 125000000, sysclk frequency in Hz.
- TICK_HZ, 1000, prescaler tick rate. DIV = CLK_HZ/TICK_HZ, integer, >=2.
- PWM_BITS, 8, width of the breathe duty and PWM counters.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  0=OFF, 1=BLINK, 2=CHASE, 3=BREATHE.
- step_ms  in  16  pattern step period in ticks; 0 is treated as 1.
- led  out  N_LED  LED drive, registered, 1 = on.
- step_pulse  out  1  one-cycle pulse on each step event, registered.

Behaviour:
- **Reset:** sampled on the rising edge while rst=1. Resets:
  - led=0, step_pulse=0
  - prescaler=0, step counter=0
  - blink phase=0
  - chase register=1 (bit0 set)
  - duty=0, direction=up
  - pwm counter=0
  - registered mode copy=mode
- **Reset mid-operation:** identical to power-up reset. There is no partial state retention.
- **Prescaler:** counts 0..DIV-1 and wraps. tick is high for one cycle when the count equals DIV-1.
- **Step counter:**
  - Increments on tick.
  - When a tick arrives with count >= max(step_ms,1)-1: the counter clears and a step event occurs in that cycle.
  - step_pulse=1 on the following edge, i.e. it rises together with the pattern update.
  - Steps occur in every mode, including OFF.
- **step_ms changed on the fly:** takes effect at the next tick comparison. If the count already exceeds the new value, the step fires on the next tick.
- **Mode change:** detected as mode differing from its registered copy.
  - On the next edge, all pattern state returns to reset values and prescaler/step counters clear; step_pulse=0 that cycle.
  - The new pattern starts from its initial value, with the first step a full period later.
  - If a mode change and a step event coincide, the mode change wins and no step is taken.
- **OFF:** led=0.
- **BLINK:** each step toggles phase; led = all bits equal to phase. The first step turns all LEDs on.
- **CHASE:** led = chase register, initially one-hot at bit0. Each step rotates left by one; bit N_LED-1 wraps to bit0. Exactly one LED is on at all times.
- **BREATHE:**
  - Each step: when direction is up, duty+1; when duty reaches 2^PWM_BITS-1, direction becomes down. When direction is down, duty-1; when duty reaches 0, direction becomes up.
  - Endpoints are not repeated: sequence 0,1,...,max,max-1,...,0,1,...
  - The pwm counter (PWM_BITS wide) free-runs on every sysclk, wrapping at 2^PWM_BITS.
  - All led bits = (pwm counter < duty). duty=0 gives always off; max gives on for max of every 2^PWM_BITS cycles.
- **Arithmetic:** all counters are unsigned and wrap modulo their width. Prescaler width = clog2(DIV); step counter is 16 bits.

Test Plan:
Use CLK_HZ=1000, TICK_HZ=100 (DIV=10) and PWM_BITS=2 unless noted. Cycles are counted from the first edge with rst=0.
1. **Blink:** mode=1, step_ms=3, release rst.
   - step_pulse high at cycle 30, 60, 90, ...
   - led=1111 from cycle 30, 0000 from 60, 1111 from 90.
2. **Chase wrap:** mode=2, step_ms=1.
   - led=0001 at reset, then 0010 at cycle 10, 0100 at 20, 1000 at 30.
   - led=0001 at 40 (wrap); never zero or multi-hot.
3. **Breathe:** mode=3, step_ms=1.
   - duty sequence per 10-cycle step: 0,1,2,3,2,1,0,1.
   - With duty=2, led=1111 exactly 2 of every 4 cycles.
   - With duty=0, led=0000 continuously.
4. **Mode switch mid-pattern:** chase at led=0100, then set mode=1.
   - Next edge: led=0000, counters cleared.
   - First step_pulse 30 cycles later with step_ms=3.
   - Mode change coincident with a step: no step_pulse.
5. **step_ms edge cases:**
   - step_ms=0: steps every 10 cycles, same as step_ms=1.
   - Count at 4 with step_ms=5, lowered to 2: step fires on the very next tick.
6. **Reset mid-operation:** assert rst for 1 cycle during breathe with duty=3 going down.
   - Next edge: led=0000, step_pulse=0, duty=0, direction up.
   - Identical trace to a fresh reset afterwards.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Board LED driver: OFF / BLINK / CHASE / BREATHE patterns stepped from a tick prescaler.
// led and step_pulse are registered; a step event is reflected on the following edge.
module led_pattern_gen #(
    parameter int N_LED    = 4,
    parameter int CLK_HZ   = 125000000,
    parameter int TICK_HZ  = 1000,
    parameter int PWM_BITS = 8
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [15:0]      step_ms,
    output logic [N_LED-1:0] led,
    output logic             step_pulse
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0]       PRESC_LAST = PW'(DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    mode_t               mode_q;
    logic [PW-1:0]       presc;
    logic [15:0]         step_cnt;
    logic                phase;
    logic [N_LED-1:0]    chase;
    logic [PWM_BITS-1:0] duty;
    logic                dir_down;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic                tick;
    logic [15:0]         step_max;
    logic                step_ev;
    logic                mode_chg;
    logic                phase_n;
    logic [N_LED-1:0]    chase_n;
    logic [PWM_BITS-1:0] duty_n;
    logic                dir_n;
    logic [PWM_BITS-1:0] pwm_n;
    logic [N_LED-1:0]    led_n;

    assign tick     = (presc == PRESC_LAST);
    // step_ms of zero behaves as one
    assign step_max = (step_ms == 16'd0) ? 16'd0 : step_ms - 16'd1;
    assign step_ev  = tick && (step_cnt >= step_max);
    assign mode_chg = (mode != mode_q);

    always_comb begin
        phase_n = phase;
        chase_n = chase;
        duty_n  = duty;
        dir_n   = dir_down;
        pwm_n   = pwm_cnt + PWM_BITS'(1);
        if (step_ev) begin
            case (mode_q)
                MODE_BLINK: phase_n = ~phase;
                MODE_CHASE: chase_n = {chase[N_LED-2:0], chase[N_LED-1]};
                MODE_BREATHE: begin
                    // turn around at the endpoints so neither value repeats
                    if (!dir_down) begin
                        duty_n = duty + PWM_BITS'(1);
                        if (duty_n == DUTY_MAX) dir_n = 1'b1;
                    end else begin
                        duty_n = duty - PWM_BITS'(1);
                        if (duty_n == '0) dir_n = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        led_n = '0;
        case (mode_q)
            MODE_BLINK:   led_n = {N_LED{phase_n}};
            MODE_CHASE:   led_n = chase_n;
            MODE_BREATHE: led_n = {N_LED{pwm_n < duty_n}};
            default:      led_n = '0;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst || mode_chg) begin
            // a mode change restarts everything exactly like a reset
            mode_q     <= mode_t'(mode);
            presc      <= '0;
            step_cnt   <= '0;
            phase      <= 1'b0;
            chase      <= N_LED'(1);
            duty       <= '0;
            dir_down   <= 1'b0;
            pwm_cnt    <= '0;
            led        <= '0;
            step_pulse <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) step_cnt <= step_ev ? 16'd0 : step_cnt + 16'd1;
            phase      <= phase_n;
            chase      <= chase_n;
            duty       <= duty_n;
            dir_down   <= dir_n;
            pwm_cnt    <= pwm_n;
            led        <= led_n;
            step_pulse <= step_ev;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with DIV=10, PWM_BITS=2, N_LED=4.
module tb_led_pattern_gen;

    logic        sysclk;
    logic        rst;
    logic [1:0]  mode;
    logic [15:0] step_ms;
    logic [3:0]  led;
    logic        step_pulse;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    led_pattern_gen #(
        .N_LED(4), .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(2)
    ) dut (
        .sysclk(sysclk), .rst(rst), .mode(mode), .step_ms(step_ms),
        .led(led), .step_pulse(step_pulse)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic clk_step();
        @(posedge sysclk);
        #1;
        cyc++;
    endtask

    // cyc counts edges after rst is released: the first such edge is cyc 1
    task automatic start(input logic [1:0] m, input logic [15:0] s);
        mode    = m;
        step_ms = s;
        rst     = 1'b1;
        clk_step();
        clk_step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        mode = 2'd2; step_ms = 16'd1; rst = 1'b1;
        clk_step();
        clk_step();
        n_cmp++;
        if (led !== 4'b0000) begin n_fail++; $display("FAIL reset_led got=%b exp=0000", led); end
        n_cmp++;
        if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got=%b exp=0", step_pulse); end
        rst = 1'b0; cyc = 0;
        clk_step();
        n_cmp++;
        if (led !== 4'b0001) begin n_fail++; $display("FAIL reset_chase_init got=%b exp=0001", led); end
    endtask

    task automatic test_blink();
        logic [3:0] el;
        logic       ep;
        start(2'd1, 16'd3);
        for (int i = 0; i < 95; i++) begin
            clk_step();
            el = (((cyc / 30) % 2) == 1) ? 4'hF : 4'h0;
            ep = ((cyc % 30) == 0);
            n_cmp++;
            if (led !== el) begin n_fail++; $display("FAIL blink_led cyc=%0d got=%b exp=%b", cyc, led, el); end
            n_cmp++;
            if (step_pulse !== ep) begin n_fail++; $display("FAIL blink_pulse cyc=%0d got=%b exp=%b", cyc, step_pulse, ep); end
        end
    endtask

    task automatic test_chase();
        logic [3:0] el;
        start(2'd2, 16'd1);
        for (int i = 0; i < 50; i++) begin
            clk_step();
            el = 4'b0001 << ((cyc / 10) % 4);
            n_cmp++;
            if (led !== el) begin n_fail++; $display("FAIL chase_led cyc=%0d got=%b exp=%b", cyc, led, el); end
            n_cmp++;
            if (!$onehot(led)) begin n_fail++; $display("FAIL chase_onehot cyc=%0d got=%b exp=onehot", cyc, led); end
        end
    endtask

    task automatic test_breathe();
        int duty_tab[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
        int on_cnt = 0;
        logic [3:0] el;
        start(2'd3, 16'd1);
        for (int i = 0; i < 79; i++) begin
            clk_step();
            el = ((cyc % 4) < duty_tab[cyc / 10]) ? 4'hF : 4'h0;
            if (cyc >= 20 && cyc <= 23 && led === 4'hF) on_cnt++;
            n_cmp++;
            if (led !== el) begin n_fail++; $display("FAIL breathe_led cyc=%0d got=%b exp=%b", cyc, led, el); end
        end
        n_cmp++;
        if (on_cnt != 2) begin n_fail++; $display("FAIL breathe_duty2_on got=%0d exp=2", on_cnt); end
    endtask

    task automatic test_mode_switch();
        logic [3:0] el;
        logic       ep;
        start(2'd2, 16'd1);
        while (cyc < 25) clk_step();
        n_cmp++;
        if (led !== 4'b0100) begin n_fail++; $display("FAIL switch_pre got=%b exp=0100", led); end
        mode = 2'd1; step_ms = 16'd3;
        clk_step();
        n_cmp++;
        if (led !== 4'b0000) begin n_fail++; $display("FAIL switch_led got=%b exp=0000", led); end
        n_cmp++;
        if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL switch_pulse got=%b exp=0", step_pulse); end
        while (cyc < 60) begin
            clk_step();
            ep = (cyc == 56);
            el = (cyc >= 56) ? 4'hF : 4'h0;
            n_cmp++;
            if (step_pulse !== ep) begin n_fail++; $display("FAIL switch_first_step cyc=%0d got=%b exp=%b", cyc, step_pulse, ep); end
            n_cmp++;
            if (led !== el) begin n_fail++; $display("FAIL switch_blink cyc=%0d got=%b exp=%b", cyc, led, el); end
        end
    endtask

    task automatic test_mode_step_coincide();
        logic ep;
        start(2'd2, 16'd1);
        while (cyc < 9) clk_step();
        mode = 2'd1;
        clk_step();
        n_cmp++;
        if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL coincide_pulse got=%b exp=0", step_pulse); end
        n_cmp++;
        if (led !== 4'b0000) begin n_fail++; $display("FAIL coincide_led got=%b exp=0000", led); end
        while (cyc < 25) begin
            clk_step();
            ep = (cyc == 20);
            n_cmp++;
            if (step_pulse !== ep) begin n_fail++; $display("FAIL coincide_next cyc=%0d got=%b exp=%b", cyc, step_pulse, ep); end
        end
    endtask

    task automatic test_step_ms();
        logic [3:0] el;
        logic       ep;
        start(2'd1, 16'd0);
        for (int i = 0; i < 35; i++) begin
            clk_step();
            ep = ((cyc % 10) == 0);
            el = (((cyc / 10) % 2) == 1) ? 4'hF : 4'h0;
            n_cmp++;
            if (step_pulse !== ep) begin n_fail++; $display("FAIL stepms0_pulse cyc=%0d got=%b exp=%b", cyc, step_pulse, ep); end
            n_cmp++;
            if (led !== el) begin n_fail++; $display("FAIL stepms0_led cyc=%0d got=%b exp=%b", cyc, led, el); end
        end
        // count already 3, new limit 2: fires on the next tick instead of at cyc 50
        start(2'd1, 16'd5);
        while (cyc < 30) clk_step();
        step_ms = 16'd2;
        while (cyc < 65) begin
            clk_step();
            ep = (cyc == 40) || (cyc == 60);
            n_cmp++;
            if (step_pulse !== ep) begin n_fail++; $display("FAIL lower_at3 cyc=%0d got=%b exp=%b", cyc, step_pulse, ep); end
        end
        start(2'd1, 16'd5);
        while (cyc < 40) clk_step();
        step_ms = 16'd2;
        while (cyc < 75) begin
            clk_step();
            ep = (cyc == 50) || (cyc == 70);
            n_cmp++;
            if (step_pulse !== ep) begin n_fail++; $display("FAIL lower_at4 cyc=%0d got=%b exp=%b", cyc, step_pulse, ep); end
        end
    endtask

    task automatic test_reset_mid();
        int duty_tab[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
        logic [3:0] el;
        start(2'd3, 16'd1);
        while (cyc < 35) clk_step();
        rst = 1'b1;
        clk_step();
        n_cmp++;
        if (led !== 4'b0000) begin n_fail++; $display("FAIL midrst_led got=%b exp=0000", led); end
        n_cmp++;
        if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL midrst_pulse got=%b exp=0", step_pulse); end
        rst = 1'b0; cyc = 0;
        for (int i = 0; i < 79; i++) begin
            clk_step();
            el = ((cyc % 4) < duty_tab[cyc / 10]) ? 4'hF : 4'h0;
            n_cmp++;
            if (led !== el) begin n_fail++; $display("FAIL midrst_trace cyc=%0d got=%b exp=%b", cyc, led, el); end
        end
    endtask

    initial begin
        rst = 1'b1; mode = 2'd0; step_ms = 16'd1;
        test_reset();
        test_blink();
        test_chase();
        test_breathe();
        test_mode_switch();
        test_mode_step_coincide();
        test_step_ms();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
